lm_sm_sequencer: RTL and testbench

- Multi-cycle sequencer for the load-multiple (LM) and store-multiple (SM) instructions.
- Sits directly upstream of the memory block and drives its access port: enable, read/write-bar, address and write data.
- Walks an 8-bit register mask from lowest set bit to highest, one memory transfer per cycle, at consecutive addresses from a base.
- Connects on the other side to the register file: write port for LM, read port for SM.

---
 rtl/lm_sm_sequencer.sv | 155 +++++++++++++++
 tb/tb_lm_sm_sequencer.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lm_sm_sequencer.sv
// lm_sm_sequencer: multi-cycle sequencer for load-multiple / store-multiple.
// Walks a register mask from its lowest set bit to its highest and issues one
// memory transfer per cycle at consecutive addresses starting from a base.
// Optional build macro LMSM_BASE_WB_EN adds a post-increment base write-back
// port that is pulsed in the completion cycle.
module lm_sm_sequencer #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 16,
  parameter int REG_COUNT  = 8,
  localparam int IDX_W     = $clog2(REG_COUNT)
) (
  input  logic                  In_clock,
  input  logic                  In_reset,
  input  logic                  In_start,
  input  logic                  In_is_store,
  input  logic [ADDR_WIDTH-1:0] In_base_addr,
  input  logic [REG_COUNT-1:0]  In_reg_mask,
  output logic                  Out_Mem_Access_en,
  output logic                  Out_Mem_Access_R_Wbar,
  output logic [ADDR_WIDTH-1:0] Out_Mem_Access_addr,
  output logic [DATA_WIDTH-1:0] Out_Mem_Write_data,
  input  logic [DATA_WIDTH-1:0] In_Mem_Read_data,
  output logic [IDX_W-1:0]      Out_Rf_rd_addr,
  input  logic [DATA_WIDTH-1:0] In_Rf_rd_data,
  output logic                  Out_Rf_wr_en,
  output logic [IDX_W-1:0]      Out_Rf_wr_addr,
  output logic [DATA_WIDTH-1:0] Out_Rf_wr_data,
  output logic                  Out_busy,
  output logic                  Out_done,
`ifdef LMSM_BASE_WB_EN
  output logic                  Out_base_wb_en,
  output logic [ADDR_WIDTH-1:0] Out_base_wb_data,
`endif
  output logic [3:0]            Out_count
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_XFER = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t                  state_reg;
  state_t                  state_next;
  logic [REG_COUNT-1:0]    rem_mask_reg;
  logic [ADDR_WIDTH-1:0]   cur_addr_reg;
  logic                    is_store_reg;
  logic [3:0]              count_reg;

  logic [IDX_W-1:0]        low_idx;
  logic [REG_COUNT-1:0]    mask_cleared;
  logic                    xfer_active;

  // Priority encoder: index of the lowest set bit of the remaining mask.
  always_comb begin
    low_idx = '0;
    for (int k = REG_COUNT - 1; k >= 0; k--) begin
      if (rem_mask_reg[k]) begin
        low_idx = IDX_W'(k);
      end
    end
  end

  // Dropping the lowest set bit is the classic x & (x - 1).
  assign mask_cleared = rem_mask_reg & (rem_mask_reg - REG_COUNT'(1));

  // Next-state decode.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: begin
        if (In_start) begin
          state_next = (In_reg_mask != '0) ? ST_XFER : ST_DONE;
        end
      end
      ST_XFER: begin
        if (mask_cleared == '0) begin
          state_next = ST_DONE;
        end
      end
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // State and datapath registers; start is only latched from IDLE.
  always_ff @(posedge In_clock) begin
    if (In_reset) begin
      state_reg    <= ST_IDLE;
      rem_mask_reg <= '0;
      cur_addr_reg <= '0;
      is_store_reg <= 1'b0;
      count_reg    <= '0;
    end else begin
      state_reg <= state_next;
      case (state_reg)
        ST_IDLE: begin
          if (In_start) begin
            rem_mask_reg <= In_reg_mask;
            cur_addr_reg <= In_base_addr;
            is_store_reg <= In_is_store;
            count_reg    <= '0;
          end
        end
        ST_XFER: begin
          rem_mask_reg <= mask_cleared;
          cur_addr_reg <= cur_addr_reg + ADDR_WIDTH'(1);
          count_reg    <= count_reg + 4'd1;
        end
        default: ;
      endcase
    end
  end

  // Reset gates the outputs in the same cycle so an abandoned operation
  // cannot commit a write on the reset edge.
  assign xfer_active = (state_reg == ST_XFER) && !In_reset;

  // Output decode of the registered state plus the combinational data paths.
  always_comb begin
    Out_Mem_Access_en     = 1'b0;
    Out_Mem_Access_R_Wbar = 1'b1;
    Out_Mem_Access_addr   = '0;
    Out_Mem_Write_data    = '0;
    Out_Rf_rd_addr        = '0;
    Out_Rf_wr_en          = 1'b0;
    Out_Rf_wr_addr        = '0;
    Out_Rf_wr_data        = '0;
    Out_busy              = xfer_active;
    Out_done              = (state_reg == ST_DONE) && !In_reset;
    Out_count             = In_reset ? 4'd0 : count_reg;
`ifdef LMSM_BASE_WB_EN
    Out_base_wb_en        = 1'b0;
    Out_base_wb_data      = '0;
    if ((state_reg == ST_DONE) && !In_reset) begin
      Out_base_wb_en   = 1'b1;
      Out_base_wb_data = cur_addr_reg;
    end
`endif
    if (xfer_active) begin
      Out_Mem_Access_en   = 1'b1;
      Out_Mem_Access_addr = cur_addr_reg;
      if (is_store_reg) begin
        Out_Mem_Access_R_Wbar = 1'b0;
        Out_Rf_rd_addr        = low_idx;
        Out_Mem_Write_data    = In_Rf_rd_data;
      end else begin
        Out_Rf_wr_en   = 1'b1;
        Out_Rf_wr_addr = low_idx;
        Out_Rf_wr_data = In_Mem_Read_data;
      end
    end
  end

endmodule

// File: tb/tb_lm_sm_sequencer.sv
// tb_lm_sm_sequencer: directed bench for lm_sm_sequencer. The bench supplies the
// memory and register file, keeps a transfer-list model of each operation and
// compares every DUT output on every falling edge.
module tb_lm_sm_sequencer;

  logic        clk;
  logic        In_reset;
  logic        In_start;
  logic        In_is_store;
  logic [15:0] In_base_addr;
  logic [7:0]  In_reg_mask;
  logic        Out_Mem_Access_en;
  logic        Out_Mem_Access_R_Wbar;
  logic [15:0] Out_Mem_Access_addr;
  logic [15:0] Out_Mem_Write_data;
  logic [15:0] In_Mem_Read_data;
  logic [2:0]  Out_Rf_rd_addr;
  logic [15:0] In_Rf_rd_data;
  logic        Out_Rf_wr_en;
  logic [2:0]  Out_Rf_wr_addr;
  logic [15:0] Out_Rf_wr_data;
  logic        Out_busy;
  logic        Out_done;
  logic [3:0]  Out_count;
`ifdef LMSM_BASE_WB_EN
  logic        Out_base_wb_en;
  logic [15:0] Out_base_wb_data;
`endif

  lm_sm_sequencer dut (
    .In_clock              (clk),
    .In_reset              (In_reset),
    .In_start              (In_start),
    .In_is_store           (In_is_store),
    .In_base_addr          (In_base_addr),
    .In_reg_mask           (In_reg_mask),
    .Out_Mem_Access_en     (Out_Mem_Access_en),
    .Out_Mem_Access_R_Wbar (Out_Mem_Access_R_Wbar),
    .Out_Mem_Access_addr   (Out_Mem_Access_addr),
    .Out_Mem_Write_data    (Out_Mem_Write_data),
    .In_Mem_Read_data      (In_Mem_Read_data),
    .Out_Rf_rd_addr        (Out_Rf_rd_addr),
    .In_Rf_rd_data         (In_Rf_rd_data),
    .Out_Rf_wr_en          (Out_Rf_wr_en),
    .Out_Rf_wr_addr        (Out_Rf_wr_addr),
    .Out_Rf_wr_data        (Out_Rf_wr_data),
    .Out_busy              (Out_busy),
    .Out_done              (Out_done),
`ifdef LMSM_BASE_WB_EN
    .Out_base_wb_en        (Out_base_wb_en),
    .Out_base_wb_data      (Out_base_wb_data),
`endif
    .Out_count             (Out_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int start_cyc = 0;
  int ops = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- environment: memory and register file ----------------
  logic [15:0] mem [0:65535] = '{default: '0};
  logic [15:0] rf  [0:7]     = '{default: '0};
  logic        pre_we;
  logic        pre_rf;
  logic [15:0] pre_addr;
  logic [15:0] pre_data;

  assign In_Mem_Read_data = mem[Out_Mem_Access_addr];
  assign In_Rf_rd_data    = rf[Out_Rf_rd_addr];

  always @(posedge clk) begin
    if (pre_we) begin
      if (pre_rf) rf[pre_addr[2:0]] <= pre_data;
      else        mem[pre_addr]     <= pre_data;
    end
    if (Out_Mem_Access_en && !Out_Mem_Access_R_Wbar) mem[Out_Mem_Access_addr] <= Out_Mem_Write_data;
    if (Out_Rf_wr_en) rf[Out_Rf_wr_addr] <= Out_Rf_wr_data;
  end

  // ---------------- model: list of expected cycles per operation ----------------
  typedef struct {
    logic        is_done;
    logic        store;
    logic [15:0] addr;
    logic [2:0]  idx;
    logic [3:0]  count;
    logic [15:0] wb;
  } rec_t;

  rec_t        q[$];
  rec_t        cur;
  logic        cur_valid = 1'b0;
  logic [3:0]  last_count = 4'd0;
  logic [15:0] exp_mem [0:65535] = '{default: '0};
  logic [15:0] exp_rf  [0:7]     = '{default: '0};

  always @(posedge clk) begin
    rec_t r;
    int   n;
    if (pre_we) begin
      if (pre_rf) exp_rf[pre_addr[2:0]] = pre_data;
      else        exp_mem[pre_addr]     = pre_data;
    end
    if (In_reset) begin
      q.delete();
      last_count = 4'd0;
    end else begin
      if (cur_valid && !cur.is_done) begin
        if (cur.store) exp_mem[cur.addr] = exp_rf[cur.idx];
        else           exp_rf[cur.idx]   = exp_mem[cur.addr];
      end
      if (!cur_valid && In_start) begin
        n = 0;
        for (int i = 0; i < 8; i++) begin
          if (In_reg_mask[i]) begin
            r.is_done = 1'b0;
            r.store   = In_is_store;
            r.addr    = In_base_addr + 16'(n);
            r.idx     = 3'(i);
            r.count   = 4'(n);
            r.wb      = 16'h0;
            q.push_back(r);
            n++;
          end
        end
        r.is_done = 1'b1;
        r.store   = In_is_store;
        r.addr    = 16'h0;
        r.idx     = 3'd0;
        r.count   = 4'(n);
        r.wb      = In_base_addr + 16'(n);
        q.push_back(r);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Per-cycle compare against the model.
  always @(negedge clk) begin
    logic        e_en, e_rwb, e_wr_en, e_busy, e_done, e_wb_en;
    logic [15:0] e_addr, e_wdata, e_rfwd, e_wb;
    logic [2:0]  e_rd, e_wa;
    logic [3:0]  e_cnt;
    if (q.size() > 0) begin
      cur = q.pop_front();
      cur_valid = 1'b1;
    end else begin
      cur_valid = 1'b0;
    end
    e_en = 1'b0; e_rwb = 1'b1; e_wr_en = 1'b0; e_busy = 1'b0; e_done = 1'b0; e_wb_en = 1'b0;
    e_addr = '0; e_wdata = '0; e_rfwd = '0; e_wb = '0; e_rd = '0; e_wa = '0;
    e_cnt = last_count;
    if (In_reset) begin
      e_cnt = 4'd0;
    end else if (cur_valid) begin
      e_cnt = cur.count;
      if (cur.is_done) begin
        e_done     = 1'b1;
        e_wb_en    = 1'b1;
        e_wb       = cur.wb;
        last_count = cur.count;
      end else begin
        e_busy = 1'b1;
        e_en   = 1'b1;
        e_addr = cur.addr;
        if (cur.store) begin
          e_rwb   = 1'b0;
          e_rd    = cur.idx;
          e_wdata = exp_rf[cur.idx];
        end else begin
          e_wr_en = 1'b1;
          e_wa    = cur.idx;
          e_rfwd  = exp_mem[cur.addr];
        end
      end
    end
    chk("mem_en",    32'(Out_Mem_Access_en),     32'(e_en));
    chk("mem_rwb",   32'(Out_Mem_Access_R_Wbar), 32'(e_rwb));
    chk("mem_addr",  32'(Out_Mem_Access_addr),   32'(e_addr));
    chk("mem_wdata", 32'(Out_Mem_Write_data),    32'(e_wdata));
    chk("rf_rd",     32'(Out_Rf_rd_addr),        32'(e_rd));
    chk("rf_wr_en",  32'(Out_Rf_wr_en),          32'(e_wr_en));
    chk("rf_wr_a",   32'(Out_Rf_wr_addr),        32'(e_wa));
    chk("rf_wr_d",   32'(Out_Rf_wr_data),        32'(e_rfwd));
    chk("busy",      32'(Out_busy),              32'(e_busy));
    chk("done",      32'(Out_done),              32'(e_done));
    chk("count",     32'(Out_count),             32'(e_cnt));
`ifdef LMSM_BASE_WB_EN
    chk("wb_en",     32'(Out_base_wb_en),        32'(e_wb_en));
    chk("wb_data",   32'(Out_base_wb_data),      32'(e_wb));
`endif
  end

  // ---------------- stimulus helpers ----------------
  task automatic poke(input logic to_rf, input logic [15:0] a, input logic [15:0] d);
    pre_we = 1'b1; pre_rf = to_rf; pre_addr = a; pre_data = d;
    @(posedge clk); #1;
    pre_we = 1'b0;
  endtask

  task automatic start_op(input logic st, input logic [15:0] base, input logic [7:0] mask);
    @(posedge clk); #1;
    In_start = 1'b1; In_is_store = st; In_base_addr = base; In_reg_mask = mask;
    @(posedge clk); #1;
    start_cyc = cyc;
    In_start = 1'b0;
    ops++;
    $display("op %0d: %s base=%04h mask=%08b", ops, st ? "SM" : "LM", base, mask);
  endtask

  // Waits (bounded) for Out_done and checks its latency from the start edge.
  task automatic wait_done(input string tag, input int n_set);
    logic seen;
    seen = 1'b0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (Out_done) begin
        seen = 1'b1;
        chk({tag, "_done_lat"}, 32'(cyc - start_cyc + 1), 32'(n_set + 1));
        break;
      end
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL %s_done_timeout: got no done, expected done within 30 cycles", tag);
    end
  endtask

  initial begin
    In_reset = 1'b1; In_start = 1'b0; In_is_store = 1'b0;
    In_base_addr = '0; In_reg_mask = '0;
    pre_we = 1'b0; pre_rf = 1'b0; pre_addr = '0; pre_data = '0;
    @(negedge clk);
    chk("rst_rwb", 32'(Out_Mem_Access_R_Wbar), 32'd1);
    chk("rst_en",  32'(Out_Mem_Access_en),     32'd0);
    repeat (2) @(posedge clk);
    #1 In_reset = 1'b0;

    // 1: LM base 20, mask 0000_0101
    poke(1'b0, 16'd20, 16'h0001);
    poke(1'b0, 16'd21, 16'h000F);
    start_op(1'b0, 16'd20, 8'b0000_0101);
    wait_done("t1", 2);
    @(negedge clk);
    chk("t1_r0", 32'(rf[0]), 32'h0001);
    chk("t1_r2", 32'(rf[2]), 32'h000F);
    chk("t1_count", 32'(Out_count), 32'd2);

    // 2: SM base 40, mask 1000_0010
    poke(1'b1, 16'd1, 16'hABCD);
    poke(1'b1, 16'd7, 16'h1234);
    start_op(1'b1, 16'd40, 8'b1000_0010);
    wait_done("t2", 2);
    @(negedge clk);
    chk("t2_m40", 32'(mem[40]), 32'hABCD);
    chk("t2_m41", 32'(mem[41]), 32'h1234);
    chk("t2_count", 32'(Out_count), 32'd2);

    // 3: empty mask
    start_op(1'b0, 16'd60, 8'h00);
    wait_done("t3", 0);
    chk("t3_count", 32'(Out_count), 32'd0);

    // 4: LM across the address wrap
    poke(1'b0, 16'hFFFF, 16'h5555);
    poke(1'b0, 16'h0000, 16'h6666);
    start_op(1'b0, 16'hFFFF, 8'h03);
    wait_done("t4", 2);
`ifdef LMSM_BASE_WB_EN
    chk("t4_wb", 32'(Out_base_wb_data), 32'h0001);
`endif
    @(negedge clk);
    chk("t4_r0", 32'(rf[0]), 32'h5555);
    chk("t4_r1", 32'(rf[1]), 32'h6666);

    // 5: SM mask FF, reset during the 4th transfer
    for (int i = 0; i < 8; i++) poke(1'b1, 16'(i), 16'h0100 + 16'(i));
    start_op(1'b1, 16'd100, 8'hFF);
    repeat (3) @(posedge clk);
    #1 In_reset = 1'b1;
    @(posedge clk);
    #1 In_reset = 1'b0;
    @(negedge clk);
    chk("t5_m100", 32'(mem[100]), 32'h0100);
    chk("t5_m101", 32'(mem[101]), 32'h0101);
    chk("t5_m102", 32'(mem[102]), 32'h0102);
    chk("t5_m103", 32'(mem[103]), 32'h0000);
    chk("t5_count", 32'(Out_count), 32'd0);
    chk("t5_busy", 32'(Out_busy), 32'd0);

    // 6: LM mask FF with a second start pulsed mid-transfer
    for (int i = 0; i < 8; i++) poke(1'b0, 16'd200 + 16'(i), 16'h0200 + 16'(i));
    start_op(1'b0, 16'd200, 8'hFF);
    In_start = 1'b1; In_is_store = 1'b1; In_base_addr = 16'd500; In_reg_mask = 8'h01;
    @(posedge clk); #1;
    In_start = 1'b0;
    wait_done("t6", 8);
    @(negedge clk);
    for (int i = 0; i < 8; i++) chk($sformatf("t6_r%0d", i), 32'(rf[i]), 32'h0200 + 32'(i));
    chk("t6_m500", 32'(mem[500]), 32'h0000);
    chk("t6_count", 32'(Out_count), 32'd8);
    start_op(1'b1, 16'd300, 8'h01);
    wait_done("t6b", 1);
    @(negedge clk);
    chk("t6b_m300", 32'(mem[300]), 32'h0200);

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, expected finish before 200000 time units");
    $fatal(1, "watchdog expired");
  end

endmodule
